// File: rtl/popcnt_argmax_seq.sv
// -----------------------------------------------------------------------------
// popcnt_argmax_seq
// Sequential argmax over frames of popcount values. One count is consumed per
// input handshake. Up to InCnt counts form a frame, and last_i can close a
// frame early. At the end of each frame the stage reports the position of the
// largest count, the count itself and the frame length. The result is held
// until the consumer accepts it.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   cnt_valid_i  cnt_i / last_i valid
//   cnt_ready_o  stage can accept an element (registered, low while holding)
//   cnt_i        unsigned popcount value
//   last_i       element closes the frame early (qualified by cnt_valid_i)
//   res_valid_o  result valid
//   res_ready_i  consumer accepts result
//   res_idx_o    frame position of the maximum (lowest index on ties)
//   res_max_o    maximum count in the frame
//   res_len_o    number of elements in the frame (1..InCnt)
// -----------------------------------------------------------------------------
module popcnt_argmax_seq #(
    parameter  int InCnt  = 4,
    parameter  int CntWdt = 16,
    localparam int IdxWdt = (InCnt > 2) ? $clog2(InCnt) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cnt_valid_i,
    output logic              cnt_ready_o,
    input  logic [CntWdt-1:0] cnt_i,
    input  logic              last_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [IdxWdt-1:0] res_idx_o,
    output logic [CntWdt-1:0] res_max_o,
    output logic [IdxWdt:0]   res_len_o
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [IdxWdt-1:0] LAST_POS = IdxWdt'(InCnt - 1);

    state_t              state_r;
    logic [IdxWdt-1:0]   pos_r;
    logic [IdxWdt-1:0]   idx_r;
    logic [CntWdt-1:0]   max_r;

    logic                accept_s;
    logic                take_s;
    logic                frame_end_s;
    logic [IdxWdt-1:0]   nxt_idx_s;
    logic [CntWdt-1:0]   nxt_max_s;
    logic [IdxWdt:0]     len_s;

    // Running-maximum update for the element currently offered. The first
    // element of a frame always seeds the maximum. Later elements replace the
    // maximum only when strictly larger, so ties keep the lowest index.
    always_comb begin
        accept_s    = cnt_valid_i & cnt_ready_o;
        take_s      = 1'b0;
        nxt_idx_s   = idx_r;
        nxt_max_s   = max_r;
        frame_end_s = last_i | (pos_r == LAST_POS);
        len_s       = {1'b0, pos_r} + {{IdxWdt{1'b0}}, 1'b1};
        if ((pos_r == {IdxWdt{1'b0}}) || (cnt_i > max_r)) begin
            take_s    = 1'b1;
            nxt_idx_s = pos_r;
            nxt_max_s = cnt_i;
        end else begin
            take_s    = 1'b0;
            nxt_idx_s = idx_r;
            nxt_max_s = max_r;
        end
    end

    // Frame FSM: accumulate elements, publish the result, hold it until the handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_ACCUM;
            pos_r       <= {IdxWdt{1'b0}};
            idx_r       <= {IdxWdt{1'b0}};
            max_r       <= {CntWdt{1'b0}};
            cnt_ready_o <= 1'b1;
            res_valid_o <= 1'b0;
            res_idx_o   <= {IdxWdt{1'b0}};
            res_max_o   <= {CntWdt{1'b0}};
            res_len_o   <= {(IdxWdt+1){1'b0}};
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (accept_s) begin
                        if (frame_end_s) begin
                            // The closing element is folded straight into the result.
                            res_idx_o   <= nxt_idx_s;
                            res_max_o   <= nxt_max_s;
                            res_len_o   <= len_s;
                            res_valid_o <= 1'b1;
                            cnt_ready_o <= 1'b0;
                            pos_r       <= {IdxWdt{1'b0}};
                            state_r     <= ST_HOLD;
                        end else begin
                            idx_r <= nxt_idx_s;
                            max_r <= nxt_max_s;
                            pos_r <= pos_r + {{(IdxWdt-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_HOLD: begin
                    if (res_valid_o && res_ready_i) begin
                        res_valid_o <= 1'b0;
                        cnt_ready_o <= 1'b1;
                        state_r     <= ST_ACCUM;
                    end
                end
                default: begin
                    state_r     <= ST_ACCUM;
                    pos_r       <= {IdxWdt{1'b0}};
                    cnt_ready_o <= 1'b1;
                    res_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcnt_argmax_seq.sv
module tb_popcnt_argmax_seq;

    localparam int IN_CNT  = 4;
    localparam int CNT_WDT = 16;
    localparam int IDX_WDT = 2;

    logic               clk;
    logic               rst_n;
    logic               cnt_valid;
    logic               cnt_ready;
    logic [CNT_WDT-1:0] cnt;
    logic               last;
    logic               res_valid;
    logic               res_ready;
    logic [IDX_WDT-1:0] res_idx;
    logic [CNT_WDT-1:0] res_max;
    logic [IDX_WDT:0]   res_len;

    int total = 0;
    int bad   = 0;

    // reference model state: elements of the open frame and the last expected result
    int frame_q[$];
    int exp_idx;
    int exp_max;
    int exp_len;

    popcnt_argmax_seq #(.InCnt(IN_CNT), .CntWdt(CNT_WDT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cnt_valid_i (cnt_valid),
        .cnt_ready_o (cnt_ready),
        .cnt_i       (cnt),
        .last_i      (last),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_idx_o   (res_idx),
        .res_max_o   (res_max),
        .res_len_o   (res_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // argmax of the closed frame: first position holding the largest value
    task automatic model_close();
        exp_idx = 0;
        exp_max = frame_q[0];
        for (int i = 1; i < frame_q.size(); i++) begin
            if (frame_q[i] > exp_max) begin
                exp_max = frame_q[i];
                exp_idx = i;
            end
        end
        exp_len = frame_q.size();
        frame_q.delete();
    endtask

    // offer one element from a negedge; returns at the negedge after acceptance
    task automatic push(input int v, input logic l);
        int guard;
        bit closes;
        guard = 0;
        cnt_valid = 1'b1;
        cnt = CNT_WDT'(v);
        last = l;
        while (!cnt_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_timeout", (guard < 50) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        frame_q.push_back(v);
        closes = l || (frame_q.size() == IN_CNT);
        if (closes) model_close();
        @(negedge clk);
        cnt_valid = 1'b0;
        last = 1'b0;
        if (!closes) begin
            chk("mid_valid", {31'd0, res_valid}, 32'd0);
            chk("mid_ready", {31'd0, cnt_ready}, 32'd1);
        end
    endtask

    task automatic idle(input int n);
        cnt_valid = 1'b0;
        cnt = CNT_WDT'($urandom);
        last = 1'($urandom);
        repeat (n) @(negedge clk);
    endtask

    // result must already be up at the negedge following the closing accept
    task automatic check_result(input string tag);
        chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        chk({tag, "_idx"}, 32'(res_idx), 32'(exp_idx));
        chk({tag, "_max"}, 32'(res_max), 32'(exp_max));
        chk({tag, "_len"}, 32'(res_len), 32'(exp_len));
        chk({tag, "_rdy_low"}, {31'd0, cnt_ready}, 32'd0);
    endtask

    task automatic handshake(input int delay);
        repeat (delay) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_max", 32'(res_max), 32'(exp_max));
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("hs_valid", {31'd0, res_valid}, 32'd0);
        chk("hs_ready", {31'd0, cnt_ready}, 32'd1);
    endtask

    task automatic run_frame(input string tag, input int a, input int b, input int c, input int d);
        push(a, 1'b0);
        push(b, 1'b0);
        push(c, 1'b0);
        push(d, 1'b0);
        check_result(tag);
        handshake(0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_idx"}, 32'(res_idx), 32'd0);
        chk({tag, "_max"}, 32'(res_max), 32'd0);
        chk({tag, "_len"}, 32'(res_len), 32'd0);
    endtask

    initial begin
        int n;
        int v;
        rst_n = 1'b0;
        cnt_valid = 1'b0;
        cnt = '0;
        last = 1'b0;
        res_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", {31'd0, cnt_ready}, 32'd1);

        // res_ready while idle has no effect
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("idle_rr_valid", {31'd0, res_valid}, 32'd0);

        run_frame("full", 4, 4, 8, 0);
        run_frame("tie5", 5, 5, 5, 5);
        run_frame("zero", 0, 0, 0, 0);
        run_frame("tie7", 1, 7, 7, 2);
        run_frame("big", 65535, 65534, 65535, 1);

        // short frame, then a full frame proves state cleared
        push(3, 1'b0);
        push(9, 1'b1);
        check_result("short");
        handshake(0);
        run_frame("after_short", 6, 1, 1, 1);

        // single-element frame and redundant last on element 4
        push(7, 1'b1);
        check_result("single");
        handshake(0);
        push(1, 1'b0);
        push(2, 1'b0);
        push(2, 1'b0);
        push(0, 1'b1);
        check_result("last4");
        handshake(0);

        // backpressure: 15 offered while result is held
        push(20, 1'b0);
        push(30, 1'b1);
        check_result("bp");
        cnt_valid = 1'b1;
        cnt = 16'd15;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", {31'd0, cnt_ready}, 32'd0);
            chk("bp_idx", 32'(res_idx), 32'(exp_idx));
            chk("bp_max", 32'(res_max), 32'(exp_max));
            chk("bp_len", 32'(res_len), 32'(exp_len));
        end
        handshake(0);
        push(15, 1'b0);
        push(1, 1'b0);
        push(2, 1'b1);
        check_result("bp_next");
        handshake(0);

        // input gaps
        push(2, 1'b0);
        idle(2);
        push(10, 1'b0);
        idle(1);
        push(3, 1'b0);
        push(1, 1'b0);
        check_result("gaps");
        handshake(1);

        // reset mid-frame
        push(12, 1'b0);
        push(3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        frame_q.delete();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("post_rst", 1, 2, 3, 4);

        // reset in hold
        push(9, 1'b0);
        push(8, 1'b1);
        check_result("pre_hold_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_hold");
        chk("rst_hold_ready", {31'd0, cnt_ready}, 32'd1);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("post_rst2", 2, 6, 1, 6);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, IN_CNT);
            for (int e = 0; e < n; e++) begin
                if ($urandom_range(0, 1) == 0) v = $urandom_range(0, 7);
                else v = $urandom_range(0, 65535);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                push(v, (e == n - 1) && ((n < IN_CNT) || ($urandom_range(0, 1) == 1)));
            end
            check_result("rand");
            handshake($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
